// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared definitions for the pipeline hazard controller:
//               opcode-class codes, sequencer state encoding and the
//               forwarding-select encodings driven to the EX operand muxes.
// Revision    : 1.0  initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  // Opcode classes (top three opcode bits)
  localparam logic [2:0] CLS_R   = 3'b000;
  localparam logic [2:0] CLS_BEQ = 3'b010;
  localparam logic [2:0] CLS_LW  = 3'b011;
  localparam logic [2:0] CLS_SW  = 3'b111;
  localparam logic [2:0] CLS_LUI = 3'b101;
  localparam logic [2:0] CLS_J   = 3'b100;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  // EX operand source selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : hazard_class_decode
// Description : Combinational opcode-class decoder. Reports which source
//               fields the instruction reads, whether it writes a register
//               and from which field (o_dstSel=1 -> rd, 0 -> rt), whether it
//               is a load or a jump, and whether the class is legal.
// Ports       : i_cls     opcode class
//               o_usesRs  reads rs        o_usesRt  reads rt
//               o_writes  writes a reg    o_dstSel  1: rd, 0: rt
//               o_isLoad  load            o_isJump  jump
//               o_legal   recognised class
// Revision    : 1.0  initial release
// ============================================================================
module hazard_class_decode
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [2:0] i_cls,
  output logic       o_usesRs,
  output logic       o_usesRt,
  output logic       o_writes,
  output logic       o_dstSel,
  output logic       o_isLoad,
  output logic       o_isJump,
  output logic       o_legal
);

  always_comb begin
    o_usesRs = 1'b0;
    o_usesRt = 1'b0;
    o_writes = 1'b0;
    o_dstSel = 1'b0;
    o_isLoad = 1'b0;
    o_isJump = 1'b0;
    o_legal  = 1'b0;
    case (i_cls)
      CLS_R: begin
        o_usesRs = 1'b1;
        o_usesRt = 1'b1;
        o_writes = 1'b1;
        o_dstSel = 1'b1;
        o_legal  = 1'b1;
      end
      CLS_BEQ: begin
        o_usesRs = 1'b1;
        o_usesRt = 1'b1;
        o_legal  = 1'b1;
      end
      CLS_LW: begin
        o_usesRs = 1'b1;
        o_writes = 1'b1;
        o_isLoad = 1'b1;
        o_legal  = 1'b1;
      end
      CLS_SW: begin
        o_usesRs = 1'b1;
        o_usesRt = 1'b1;
        o_writes = 1'b1;
        o_legal  = 1'b1;
      end
      CLS_LUI: begin
        o_writes = 1'b1;
        o_legal  = 1'b1;
      end
      CLS_J: begin
        o_isJump = 1'b1;
        o_legal  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall / flush / forwarding sequencer for a 5-stage pipeline.
//               Tracks in-flight destinations, stalls one cycle on load-use,
//               flushes on jumps (ID) and taken branches (EX), and registers
//               ALU operand forwarding selects as each instruction issues.
// Ports       : clk, rst_n (async, active low)
//               id_valid/id_opcode/id_rs/id_rt/id_rd : instruction in ID
//               ex_br_taken : taken branch resolved in EX
//               pc_write, ifid_write, ifid_flush, idex_bubble, jump_sel
//               fwd_a, fwd_b : registered EX operand selects
//               stall_cnt    : saturating load-use stall count
// Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int OP_W         = 6,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_br_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              jump_sel,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [15:0]       stall_cnt
);

  // Remaining FLUSH-state cycles after the branch cycle itself
  localparam logic [1:0] c_FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  logic w_usesRs, w_usesRt, w_writes, w_dstSel, w_isLoad, w_isJump, w_legal;
  logic [REG_AW-1:0] w_dst;
  logic              w_dstValid;
  logic              w_loadUse;
  logic              w_issue;
  logic              w_stall;
  logic [1:0]        w_fwdA, w_fwdB;
  state_t            w_nextState;
  logic [1:0]        w_nextCnt;
  logic              w_unusedOpBits;

  // Scoreboard. The WB slot is not tracked: nothing forwards from WB, since
  // the register file is written before it is read in the same cycle.
  logic              r_exValid, r_exIsLoad, r_memValid;
  logic [REG_AW-1:0] r_exDst, r_memDst;
  state_t            r_state;
  logic [1:0]        r_flushCnt;
  logic [1:0]        r_fwdA, r_fwdB;
  logic [15:0]       r_stallCnt;

  // Only the class field of the opcode matters here
  assign w_unusedOpBits = ^id_opcode[OP_W-4:0];

  hazard_class_decode u_decode (
    .i_cls    (id_opcode[OP_W-1:OP_W-3]),
    .o_usesRs (w_usesRs),
    .o_usesRt (w_usesRt),
    .o_writes (w_writes),
    .o_dstSel (w_dstSel),
    .o_isLoad (w_isLoad),
    .o_isJump (w_isJump),
    .o_legal  (w_legal)
  );

  assign w_dst      = w_dstSel ? id_rd : id_rt;
  // Register 0 is hardwired, so it never becomes a scoreboard destination
  assign w_dstValid = w_writes && (w_dst != '0);

  assign w_loadUse = id_valid && r_exValid && r_exIsLoad && (r_exDst != '0) &&
                     (((r_exDst == id_rs) && w_usesRs) ||
                      ((r_exDst == id_rt) && w_usesRt));

  // A load in EX cannot forward yet; that case is covered by the stall
  assign w_fwdA = (r_exValid && !r_exIsLoad && (r_exDst != '0) && (r_exDst == id_rs)) ? FWD_EXMEM :
                  (r_memValid && (r_memDst != '0) && (r_memDst == id_rs))              ? FWD_MEMWB :
                                                                                         FWD_RF;
  assign w_fwdB = (r_exValid && !r_exIsLoad && (r_exDst != '0) && (r_exDst == id_rt)) ? FWD_EXMEM :
                  (r_memValid && (r_memDst != '0) && (r_memDst == id_rt))              ? FWD_MEMWB :
                                                                                         FWD_RF;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    jump_sel    = 1'b0;
    w_issue     = 1'b0;
    w_stall     = 1'b0;
    w_nextState = r_state;
    w_nextCnt   = r_flushCnt;
    case (r_state)
      ST_RUN: begin
        if (w_loadUse) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          w_stall     = 1'b1;
          w_nextState = ST_LDSTALL;
        end else if (id_valid && w_isJump) begin
          // The jump redirects fetch and itself leaves an empty EX slot
          jump_sel   = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          w_issue = id_valid && w_legal;
        end
      end
      ST_LDSTALL: begin
        // EX holds the bubble now, so the held reader issues unconditionally
        w_issue     = id_valid && w_legal && !w_isJump;
        w_nextState = ST_RUN;
      end
      ST_FLUSH: begin
        ifid_flush = 1'b1;
        if (r_flushCnt <= 2'd1) begin
          w_nextState = ST_RUN;
          w_nextCnt   = 2'd0;
        end else begin
          w_nextCnt = r_flushCnt - 2'd1;
        end
      end
      default: w_nextState = ST_RUN;
    endcase

    // A taken branch wins over everything, including a pending stall
    if (ex_br_taken) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      jump_sel    = 1'b0;
      w_issue     = 1'b0;
      w_stall     = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        w_nextState = ST_FLUSH;
        w_nextCnt   = c_FLUSH_INIT;
      end else begin
        w_nextState = ST_RUN;
        w_nextCnt   = 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RUN;
      r_flushCnt <= 2'd0;
      r_exValid  <= 1'b0;
      r_exIsLoad <= 1'b0;
      r_exDst    <= '0;
      r_memValid <= 1'b0;
      r_memDst   <= '0;
      r_fwdA     <= FWD_RF;
      r_fwdB     <= FWD_RF;
      r_stallCnt <= 16'd0;
    end else begin
      r_state    <= w_nextState;
      r_flushCnt <= w_nextCnt;
      r_memValid <= r_exValid;
      r_memDst   <= r_exDst;
      r_exValid  <= w_issue && w_dstValid;
      r_exIsLoad <= w_issue && w_isLoad;
      r_exDst    <= w_issue ? w_dst : '0;
      r_fwdA     <= w_issue ? w_fwdA : FWD_RF;
      r_fwdB     <= w_issue ? w_fwdB : FWD_RF;
      if (w_stall && (r_stallCnt != 16'hFFFF)) begin
        r_stallCnt <= r_stallCnt + 16'd1;
      end
    end
  end

  assign fwd_a     = r_fwdA;
  assign fwd_b     = r_fwdB;
  assign stall_cnt = r_stallCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2).
//               Directed scenarios followed by random instruction streams,
//               compared against an instruction-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int FC = 2;

  localparam logic [5:0] OP_R   = 6'b000_000;
  localparam logic [5:0] OP_BEQ = 6'b010_000;
  localparam logic [5:0] OP_LW  = 6'b011_000;
  localparam logic [5:0] OP_SW  = 6'b111_000;
  localparam logic [5:0] OP_LUI = 6'b101_000;
  localparam logic [5:0] OP_J   = 6'b100_000;
  localparam logic [5:0] OP_BAD = 6'b001_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [5:0]  id_opcode = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        ex_br_taken = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, jump_sel;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .OP_W(6), .FLUSH_CYCLES(FC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .ex_br_taken (ex_br_taken),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .jump_sel    (jump_sel),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall_cnt   (stall_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of in-flight writers, index 0 = EX, 1 = MEM.
  // An entry exists only for an instruction that writes a nonzero register.
  bit         mV[2];
  logic [4:0] mD[2];
  bit         mL[2];
  int         flushLeft;
  logic [1:0] mFwdA, mFwdB;
  int         mStall;
  bit         mStalledLast;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mV[i] = 1'b0; mD[i] = '0; mL[i] = 1'b0;
    end
    flushLeft = 0; mFwdA = 2'b00; mFwdB = 2'b00; mStall = 0; mStalledLast = 1'b0;
  endtask

  function automatic logic [1:0] srcOf(input logic [4:0] r);
    if (mV[0] && !mL[0] && mD[0] == r) return 2'b10;
    if (mV[1] && mD[1] == r) return 2'b01;
    return 2'b00;
  endfunction

  // One clock of ID traffic: drive, check against model, advance model.
  task automatic step(input bit v, input logic [5:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input bit br);
    bit rsU = 0, rtU = 0, lg = 0, ld = 0, isJ = 0, wr = 0, issue = 0;
    logic [4:0] dst = '0;
    bit ePc = 1, eIfw = 1, eFl = 0, eBub = 0, eJ = 0;
    @(negedge clk);
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_br_taken = br;
    #1;
    case (op[5:3])
      3'b000: begin rsU = 1; rtU = 1; wr = 1; dst = rd; lg = 1; end
      3'b010: begin rsU = 1; rtU = 1; lg = 1; end
      3'b011: begin rsU = 1; wr = 1; dst = rt; ld = 1; lg = 1; end
      3'b111: begin rsU = 1; rtU = 1; wr = 1; dst = rt; lg = 1; end
      3'b101: begin wr = 1; dst = rt; lg = 1; end
      3'b100: begin isJ = 1; lg = 1; end
      default: ;
    endcase
    if (dst == 0) wr = 0;
    mStalledLast = 1'b0;
    if (br) begin
      eFl = 1; eBub = 1; flushLeft = FC - 1;
    end else if (flushLeft > 0) begin
      eFl = 1; flushLeft--;
    end else if (v && mV[0] && mL[0] && ((mD[0] == rs && rsU) || (mD[0] == rt && rtU))) begin
      ePc = 0; eIfw = 0; eBub = 1; mStalledLast = 1'b1;
    end else if (v && isJ) begin
      eJ = 1; eFl = 1;
    end else begin
      issue = v && lg;
    end
    chk("pc_write",    16'(pc_write),    16'(ePc));
    chk("ifid_write",  16'(ifid_write),  16'(eIfw));
    chk("ifid_flush",  16'(ifid_flush),  16'(eFl));
    chk("idex_bubble", 16'(idex_bubble), 16'(eBub));
    chk("jump_sel",    16'(jump_sel),    16'(eJ));
    chk("fwd_a",       16'(fwd_a),       16'(mFwdA));
    chk("fwd_b",       16'(fwd_b),       16'(mFwdB));
    chk("stall_cnt",   stall_cnt,        16'(mStall));
    // state seen after the coming clock edge
    if (mStalledLast && mStall < 65535) mStall++;
    mFwdA = issue ? srcOf(rs) : 2'b00;
    mFwdB = issue ? srcOf(rt) : 2'b00;
    mV[1] = mV[0]; mD[1] = mD[0]; mL[1] = mL[0];
    mV[0] = issue && wr; mD[0] = dst; mL[0] = issue && ld;
  endtask

  logic [5:0] rOp;
  logic [4:0] rRs, rRt, rRd;
  bit         rV, rBr;

  initial begin
    modelReset();
    #1;
    chk("rst_pc_write",  16'(pc_write),   16'd1);
    chk("rst_ifid_write",16'(ifid_write), 16'd1);
    chk("rst_flush",     16'(ifid_flush), 16'd0);
    chk("rst_fwd_a",     16'(fwd_a),      16'd0);
    chk("rst_stall_cnt", stall_cnt,       16'd0);
    @(negedge clk); rst_n = 1'b1;

    // load-use: lw r2; add reading r2 as rs
    step(1, OP_LW, 5'd1, 5'd2, 5'd0, 0);
    step(1, OP_R,  5'd2, 5'd5, 5'd7, 0);   // stall
    step(1, OP_R,  5'd2, 5'd5, 5'd7, 0);   // held reader issues
    @(posedge clk); #1;
    chk("tp_ldu_fwd_a", 16'(fwd_a), 16'b01);
    chk("tp_ldu_cnt",   stall_cnt,  16'd1);

    // EX/MEM then MEM/WB forwarding on rt
    step(1, OP_R, 5'd0, 5'd0, 5'd3, 0);
    step(1, OP_R, 5'd9, 5'd3, 5'd10, 0);
    step(1, OP_R, 5'd0, 5'd0, 5'd3, 0);
    step(1, OP_LUI, 5'd0, 5'd11, 5'd0, 0);
    step(1, OP_R, 5'd9, 5'd3, 5'd12, 0);
    step(0, OP_R, 5'd0, 5'd0, 5'd0, 0);

    // lw to r0 never stalls or forwards
    step(1, OP_LW, 5'd1, 5'd0, 5'd0, 0);
    step(1, OP_R,  5'd0, 5'd0, 5'd13, 0);
    step(0, OP_R,  5'd0, 5'd0, 5'd0, 0);

    // taken branch alongside a load-use hazard
    step(1, OP_LW, 5'd1, 5'd6, 5'd0, 0);
    step(1, OP_R,  5'd6, 5'd1, 5'd14, 1);
    step(0, OP_R,  5'd0, 5'd0, 5'd0, 0);
    step(1, OP_R,  5'd0, 5'd0, 5'd0, 0);
    chk("tp_br_cnt", stall_cnt, 16'd1);

    // jump, then reader of a register nobody recent writes
    step(1, OP_J,  5'd0, 5'd0, 5'd0, 0);
    step(0, OP_R,  5'd0, 5'd0, 5'd0, 0);
    step(1, OP_SW, 5'd4, 5'd4, 5'd0, 0);
    step(1, OP_BEQ, 5'd4, 5'd4, 5'd0, 0);
    step(1, OP_BAD, 5'd4, 5'd4, 5'd4, 0);

    // reset in the middle of a load-use stall
    step(1, OP_LW, 5'd1, 5'd8, 5'd0, 0);
    step(1, OP_R,  5'd8, 5'd1, 5'd15, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_pc_write",  16'(pc_write),    16'd1);
    chk("rstmid_bubble",    16'(idex_bubble), 16'd0);
    chk("rstmid_stall_cnt", stall_cnt,        16'd0);
    chk("rstmid_fwd_a",     16'(fwd_a),       16'd0);
    modelReset();
    @(negedge clk); rst_n = 1'b1;
    step(1, OP_R, 5'd8, 5'd8, 5'd16, 0);
    step(0, OP_R, 5'd0, 5'd0, 5'd0, 0);

    // random streams over a small register set to provoke hazards
    rV = 0; rOp = '0; rRs = '0; rRt = '0; rRd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!mStalledLast) begin
        rV  = ($urandom_range(0, 9) != 0);
        rOp = {3'($urandom_range(0, 7)), 3'($urandom)};
        rRs = 5'($urandom_range(0, 3));
        rRt = 5'($urandom_range(0, 3));
        rRd = 5'($urandom_range(0, 3));
      end
      rBr = ($urandom_range(0, 11) == 0);
      step(rV, rOp, rRs, rRt, rRd, rBr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Stall, flush and forwarding sequencer for the 5-stage pipeline built around the opcode-class decoder.
- Decodes each ID-stage opcode class and tracks destination registers of in-flight instructions in an internal EX/MEM/WB scoreboard.
- Detects load-use hazards and resolves jumps (ID) and taken branches (EX) by driving PC/IF-ID write enables, flushes and ID/EX bubble insertion.
- Produces registered forwarding selects for the ALU operands of the instruction entering EX.

Parameters:
- REG_AW, 5, register address width
- OP_W, 6, opcode width; class = opcode[OP_W-1:OP_W-3]
- FLUSH_CYCLES, 1, cycles of IF/ID flush after a taken branch (1..3)

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  IF/ID holds a real instruction
- id_opcode  in  OP_W  opcode in ID
- id_rs  in  REG_AW  source register 1
- id_rt  in  REG_AW  source 2 / I-type destination
- id_rd  in  REG_AW  R-type destination
- ex_br_taken  in  1  branch in EX resolved taken (pulse)
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  clear IF/ID to bubble
- idex_bubble  out  1  load bubble (all controls 0) into ID/EX
- jump_sel  out  1  PC mux selects jump target this cycle
- fwd_a  out  2  EX operand A: 00 regfile, 10 EX/MEM, 01 MEM/WB
- fwd_b  out  2  EX operand B, same encoding
- stall_cnt  out  16  saturating count of load-use stall cycles

Behaviour:
- Class decode: 000 R (writes rd, reads rs, rt); 010 beq (reads rs, rt); 011 lw (writes rt, reads rs, is_load); 111 sw (writes rt, reads rs, rt); 101 lui (writes rt); 100 jump (no reads or writes). Other classes are treated as invalid and issued as a bubble. Destination 0 never writes.
- Scoreboard slots EX, MEM, WB, each {valid, dst, is_load}. Each cycle WB<-MEM and MEM<-EX. EX<-decoded ID instruction, or an invalid slot when a bubble is issued.
- Load-use hazard: EX.valid & EX.is_load & EX.dst!=0 & (EX.dst==id_rs & uses_rs | EX.dst==id_rt & uses_rt).
- FSM states RUN, LDSTALL, FLUSH. Reset state RUN.
- RUN, load-use hazard: combinationally pc_write=0, ifid_write=0, idex_bubble=1. Next state LDSTALL.
- LDSTALL lasts exactly 1 cycle. The hazard cannot recur because EX now holds the bubble. Next state RUN.
- ex_br_taken in any state: ifid_flush=1, idex_bubble=1, pc_write=1. This overrides a stall. Next state FLUSH with counter=FLUSH_CYCLES-1; with FLUSH_CYCLES=1, FLUSH is skipped.
- FLUSH: ifid_flush=1 and the ID instruction is ignored. The counter decrements; at 0 the FSM returns to RUN.
- Jump: valid class 100 in RUN with no hazard or branch. jump_sel=1, ifid_flush=1 for 1 cycle, and the jump itself issues to EX as invalid.
- Priority: ex_br_taken > load-use stall > jump.
- Forwarding is computed in ID and registered as the instruction issues. Per operand, 10 if EX slot valid & dst match & dst!=0 & !is_load. Else 01 if MEM slot valid & match & dst!=0. Else 00.
- When a bubble issues, fwd_a and fwd_b register 00.
- stall_cnt increments on each load-use stall cycle and saturates at 0xFFFF.
- Default outputs: pc_write=1, ifid_write=1, all others 0.
- Reset is asynchronous: scoreboard slots invalid, FSM RUN, fwd_a/fwd_b=00, stall_cnt=0, flush counter 0. Asserting reset mid-stall or mid-flush aborts it immediately.

Decomposition:
- Shared package: class localparams (CLS_R=000, CLS_BEQ=010, CLS_LW=011, CLS_SW=111, CLS_LUI=101, CLS_J=100), FSM state encoding, FWD_* encodings.
- One sub-module, hazard_class_decode (combinational): class -> {uses_rs, uses_rt, writes, dst_sel, is_load, is_jump, legal}.

Test Plan:
- lw r2 then R-type reading r2 as rs -> one cycle pc_write=0, ifid_write=0, idex_bubble=1. Next cycle fwd_a=01 registered. stall_cnt=1.
- R-type writing r3, then R-type reading r3 as rt -> no stall, fwd_b=10. Same with one instruction between -> fwd_b=01.
- lw to r0 followed by a reader of r0 -> no stall, fwd=00.
- ex_br_taken together with a load-use hazard, FLUSH_CYCLES=2 -> ifid_flush=1 for 2 cycles, idex_bubble=1 on the first, pc_write=1, no stall, stall_cnt unchanged.
- Jump in ID -> jump_sel=1 and ifid_flush=1 for exactly 1 cycle. The EX slot is invalid, so the next reader gets fwd=00.
- Assert rst_n=0 during LDSTALL -> outputs immediately default (pc_write=1, stall_cnt=0). After release, a reader of the prior load's register sees no stall.
